pwm_dead_time_gen: RTL and testbench

Downstream consumer of the free-running 4-bit up counter. Compares the counter value against a programmable duty and produces a pair of complementary PWM outputs with inserted dead time. New duty values arrive through a valid/ready handshake, are held in a shadow register, and take effect only at a counter wrap, so each PWM period is glitch-free. Drives the gate-driver pins.

---
 rtl/pwm_dead_time_gen_pkg.sv | 10 +
 rtl/pwm_dead_time_core.sv | 48 ++++
 rtl/pwm_dead_time_gen.sv | 95 +++++++++
 tb/tb_pwm_dead_time_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dead_time_gen_pkg.sv
// Shared defaults for the PWM dead-time generator.
package pwm_dead_time_gen_pkg;

  localparam int unsigned CNT_W_DEFAULT  = 4;
  localparam int unsigned DEAD_DEFAULT   = 2;
  localparam int unsigned DT_W_DEFAULT   = 4;
  // Duty must be able to express 2^CNT_W (always on), hence one extra bit.
  localparam int unsigned DUTY_W_DEFAULT = CNT_W_DEFAULT + 1;

endpackage

// File: rtl/pwm_dead_time_core.sv
// Dead-time insertion: holds both drives low for DEAD cycles after every raw
// edge and after enable rises, so high and low side never conduct together.
module pwm_dead_time_core
  import pwm_dead_time_gen_pkg::*;
#(
  parameter int unsigned DEAD = DEAD_DEFAULT,
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_d,
  input  logic raw_q,
  input  logic en,
  output logic pwm_h,
  output logic pwm_l
);

  localparam logic [DT_W-1:0] DeadLoad = DT_W'(DEAD);

  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;

  // Reload on the same edge raw_q takes its new value (raw_d differs), so the
  // dead window starts exactly with the raw transition.
  always_comb begin
    dt_cnt_d = dt_cnt_q;
    if (!en || (raw_d != raw_q)) begin
      dt_cnt_d = DeadLoad;
    end else if (dt_cnt_q != '0) begin
      dt_cnt_d = dt_cnt_q - DT_W'(1);
    end
  end

  // Dead-time counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_cnt_q <= DeadLoad;
    end else begin
      dt_cnt_q <= dt_cnt_d;
    end
  end

  // Drives are gated combinationally by en so disable acts immediately.
  always_comb begin
    pwm_h = en && raw_q && (dt_cnt_q == '0);
    pwm_l = en && !raw_q && (dt_cnt_q == '0);
  end

endmodule

// File: rtl/pwm_dead_time_gen.sv
// Complementary PWM generator: wrap detect on the upstream count, shadowed
// duty with valid/ready load, duty compare, and dead-time insertion.
module pwm_dead_time_gen
  import pwm_dead_time_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned DEAD  = DEAD_DEFAULT,
  parameter int unsigned DT_W  = DT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] count_in,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W:0]   cfg_duty,
  output logic             cfg_ready,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic             period_start,
  output logic             upd_done
);

  localparam int unsigned DUTY_W = CNT_W + 1;

  logic [CNT_W-1:0]  count_q;
  logic [DUTY_W-1:0] active_duty_q, shadow_q, eff_duty;
  logic              pending_q, raw_q, raw_d;
  logic              period_start_q, upd_done_q;
  logic              start, apply, xfer;

  // Wrap detect, transfer/apply qualifiers and duty compare.
  always_comb begin
    start    = (count_in == '0) && (count_q != '0);
    apply    = start && pending_q;
    xfer     = cfg_valid && !pending_q;
    // A duty applied at this wrap already governs the first cycle of the period.
    eff_duty = apply ? shadow_q : active_duty_q;
    raw_d    = eff_duty > {1'b0, count_in};
  end

  assign cfg_ready    = !pending_q;
  assign period_start = period_start_q;
  assign upd_done     = upd_done_q;

  // Previous count; all-ones at reset so the first zero counts as a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '1;
    end else begin
      count_q <= count_in;
    end
  end

  // Shadow load on handshake, promotion to active duty on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_duty_q <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
    end else if (apply) begin
      active_duty_q <= shadow_q;
      pending_q     <= 1'b0;
    end else if (xfer) begin
      shadow_q  <= cfg_duty;
      pending_q <= 1'b1;
    end
  end

  // Registered compare result and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q          <= 1'b0;
      period_start_q <= 1'b0;
      upd_done_q     <= 1'b0;
    end else begin
      raw_q          <= raw_d;
      period_start_q <= start;
      upd_done_q     <= apply;
    end
  end

  pwm_dead_time_core #(
    .DEAD (DEAD),
    .DT_W (DT_W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_d (raw_d),
    .raw_q (raw_q),
    .en    (en),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

endmodule

// File: tb/tb_pwm_dead_time_gen.sv
// Scoreboard bench: the driver advances a behavioural model each cycle and
// queues the expected outputs; a negedge monitor pops and compares.
module tb_pwm_dead_time_gen;

  localparam int unsigned DEAD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] count_in;
  logic       en;
  logic       cfg_valid;
  logic [4:0] cfg_duty;
  logic       cfg_ready, pwm_h, pwm_l, period_start, upd_done;

  always #5 clk = ~clk;

  pwm_dead_time_gen #(
    .CNT_W (4),
    .DEAD  (DEAD),
    .DT_W  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .count_in     (count_in),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_duty     (cfg_duty),
    .cfg_ready    (cfg_ready),
    .pwm_h        (pwm_h),
    .pwm_l        (pwm_l),
    .period_start (period_start),
    .upd_done     (upd_done)
  );

  typedef struct {
    logic h;
    logic l;
    logic ps;
    logic upd;
    logic rdy;
  } exp_t;

  typedef struct {
    bit raw;
    bit en;
  } hist_t;

  exp_t  exp_q[$];
  hist_t hist[$];

  int compared   = 0;
  int mismatched = 0;

  // Model state.
  logic [3:0] m_cnt_prev;
  logic [4:0] m_active, m_shadow;
  bit         m_pending, m_raw, m_ps, m_upd;

  // Inputs presented during the previous cycle (what the DUT sampled).
  bit         p_rst, p_valid;
  logic [3:0] p_cnt;
  logic [4:0] p_duty;

  task automatic check(input string name, input logic act, input logic expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pwm_h", pwm_h, e.h);
      check("pwm_l", pwm_l, e.l);
      check("period_start", period_start, e.ps);
      check("upd_done", upd_done, e.upd);
      check("cfg_ready", cfg_ready, e.rdy);
      check("no_overlap", pwm_h & pwm_l, 1'b0);
    end
  end

  function automatic void model_reset();
    m_cnt_prev = 4'hf;
    m_active   = '0;
    m_shadow   = '0;
    m_pending  = 0;
    m_raw      = 0;
    m_ps       = 0;
    m_upd      = 0;
    hist.delete();
  endfunction

  // One clock edge of the specified behaviour, using last cycle's inputs.
  function automatic bit model_step();
    bit         wrap, apply, take;
    logic [4:0] duty;
    wrap  = (p_cnt == 4'd0) && (m_cnt_prev != 4'd0);
    apply = wrap && m_pending;
    take  = p_valid && !m_pending;
    duty  = apply ? m_shadow : m_active;
    m_raw = int'(duty) > int'(p_cnt);
    m_ps  = wrap;
    m_upd = apply;
    if (apply) begin
      m_active  = m_shadow;
      m_pending = 0;
    end else if (take) begin
      m_shadow  = p_duty;
      m_pending = 1;
    end
    m_cnt_prev = p_cnt;
    return take;
  endfunction

  // Drives are allowed only once raw level and enable have both held for
  // DEAD+1 consecutive cycles since reset.
  function automatic bit settled();
    int n = int'(DEAD) + 1;
    if (hist.size() < n) return 0;
    for (int i = 0; i < n; i++) begin
      if (!hist[hist.size()-1-i].en || (hist[hist.size()-1-i].raw != m_raw)) return 0;
    end
    return 1;
  endfunction

  task automatic tick(input bit n_rst, input bit n_en, input bit want_v,
                      input logic [4:0] want_d, input bit fz);
    bit   accepted;
    exp_t e;
    hist_t h;
    @(posedge clk);
    accepted = 0;
    if (p_rst) accepted = model_step();
    #1;
    rst_n    = n_rst;
    en       = n_en;
    count_in = fz ? 4'd0 : 4'(p_cnt + 4'd1);
    if (!n_rst) begin
      cfg_valid = 1'b0;
    end else if (!(p_valid && !accepted)) begin
      cfg_valid = want_v;
      cfg_duty  = want_d;
    end
    if (!n_rst) begin
      model_reset();
    end else begin
      h.raw = m_raw;
      h.en  = n_en;
      hist.push_back(h);
      if (hist.size() > 16) void'(hist.pop_front());
    end
    e.h   = n_rst && n_en && m_raw && settled();
    e.l   = n_rst && n_en && !m_raw && settled();
    e.ps  = m_ps;
    e.upd = m_upd;
    e.rdy = !m_pending;
    exp_q.push_back(e);
    p_rst   = n_rst;
    p_cnt   = count_in;
    p_valid = cfg_valid;
    p_duty  = cfg_duty;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, 5'd0, 0);
  endtask

  task automatic idle_until(input logic [3:0] c);
    for (int i = 0; i < 16 && 4'(p_cnt + 4'd1) != c; i++) tick(1, 1, 0, 5'd0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    count_in  = 4'd0;
    cfg_valid = 1'b0;
    cfg_duty  = '0;
    p_rst     = 0;
    p_cnt     = 4'd0;
    p_valid   = 0;
    p_duty    = '0;
    model_reset();

    tick(0, 0, 0, 5'd0, 0);
    tick(0, 0, 0, 5'd0, 0);
    // Duty 4 steady state.
    tick(1, 1, 1, 5'd4, 0);
    idle(48);
    // Duty 0 then full-scale 16.
    tick(1, 1, 1, 5'd0, 0);
    idle(24);
    tick(1, 1, 1, 5'd16, 0);
    idle(40);
    // Write 8 at count 5, then 12 held off until the shadow frees.
    idle_until(4'd5);
    tick(1, 1, 1, 5'd8, 0);
    tick(1, 1, 1, 5'd12, 0);
    idle(40);
    // Transfer on a wrap cycle with nothing pending.
    idle_until(4'd0);
    tick(1, 1, 1, 5'd10, 0);
    idle(40);
    // Disable mid high phase for three cycles.
    idle_until(4'd3);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 5'd0, 0);
    idle(30);
    // Reset with a write pending.
    idle_until(4'd6);
    tick(1, 1, 1, 5'd2, 0);
    tick(1, 1, 0, 5'd0, 0);
    tick(0, 1, 0, 5'd0, 0);
    tick(0, 1, 0, 5'd0, 0);
    idle(36);
    // Count discontinuity forcing 0 mid period.
    tick(1, 1, 1, 5'd7, 0);
    idle_until(4'd9);
    tick(1, 1, 0, 5'd0, 1);
    idle(20);
    // Randomised traffic including saturating duties.
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
           ($urandom_range(0, 49) == 0));
    end
    idle(4);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
